// File: rtl/scs8hd_a2bb2oi_pipe_pkg.sv
// Shared types and the per-lane bit function for the pipelined a2bb2oi family.
// The enum encoding matches the MODE input pins.
package scs8hd_aoi_pkg;

   typedef enum logic [1:0] {
      AOI_A2BB2OI = 2'b00,
      AOI_A2BB2O  = 2'b01,
      AOI_O2BB2AI = 2'b10,
      AOI_O2BB2A  = 2'b11
   } aoi_mode_e;

   localparam int STAGES_MAX = 4;

   function automatic logic lane_fn(aoi_mode_e mode, logic a1n, logic a2n, logic b1, logic b2);
      logic a_s;
      logic o_s;
      logic r_s;
      a_s = ~a1n & ~a2n;
      o_s = ~a1n | ~a2n;
      case (mode)
         AOI_A2BB2OI: r_s = ~(a_s | (b1 & b2));
         AOI_A2BB2O:  r_s =   a_s | (b1 & b2);
         AOI_O2BB2AI: r_s = ~(o_s & (b1 | b2));
         AOI_O2BB2A:  r_s =   o_s & (b1 | b2);
         default:     r_s = 1'b0;
      endcase
      return r_s;
   endfunction

endpackage

// File: rtl/scs8hd_a2bb2oi_pipe_if.sv
// Producer/consumer bus of the pipelined a2bb2oi block: input channel, output channel
// and their valid/ready pairs. The master drives operands and OUT_READY.
interface scs8hd_a2bb2oi_pipe_if #(
   parameter int WIDTH = 8
);
   import scs8hd_aoi_pkg::*;

   localparam int POP_W = $clog2(WIDTH + 1);

   logic             IN_VALID;
   logic             IN_READY;
   logic [1:0]       MODE;
   logic [WIDTH-1:0] A1N;
   logic [WIDTH-1:0] A2N;
   logic [WIDTH-1:0] B1;
   logic [WIDTH-1:0] B2;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [WIDTH-1:0] Y;
   logic [POP_W-1:0] Y_POP;

   modport master (
      output IN_VALID, MODE, A1N, A2N, B1, B2, OUT_READY,
      input  IN_READY, OUT_VALID, Y, Y_POP
   );

   modport slave (
      input  IN_VALID, MODE, A1N, A2N, B1, B2, OUT_READY,
      output IN_READY, OUT_VALID, Y, Y_POP
   );

endinterface

// File: rtl/scs8hd_a2bb2oi_pipe_slice.sv
// One elastic register slice: holds a single word, accepts a new one whenever it is
// empty or its current word leaves in the same cycle.
module scs8hd_pipe_slice #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   logic          full_q;
   logic          full_d;
   logic [DW-1:0] data_q;
   logic [DW-1:0] data_d;
   logic          load_s;

   // Ready is held low during reset so nothing is accepted while flushing.
   always_comb begin
      in_ready = ~rst & (~full_q | out_ready);
      load_s   = in_valid & in_ready;
      full_d   = full_q;
      data_d   = data_q;
      if (load_s) begin
         full_d = 1'b1;
         data_d = in_data;
      end else if (full_q && out_ready) begin
         full_d = 1'b0;
      end else begin
         full_d = full_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign out_valid = full_q;
   assign out_data  = data_q;

endmodule

// File: rtl/scs8hd_a2bb2oi_pipe.sv
// WIDTH-lane selectable AOI/OAI bit logic with popcount, carried through a chain of
// STAGES elastic slices; the first slice registers the function result.
module scs8hd_a2bb2oi_pipe
   import scs8hd_aoi_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic                   CLK,
   input  logic                   RESET,
   scs8hd_a2bb2oi_pipe_if.slave   bus
);

   localparam int POP_W      = $clog2(WIDTH + 1);
   localparam int DW         = WIDTH + POP_W;
   // Out-of-range depths are clamped rather than producing an empty chain.
   localparam int NUM_STAGES = (STAGES < 1) ? 1 : ((STAGES > STAGES_MAX) ? STAGES_MAX : STAGES);

   logic [WIDTH-1:0] y_s;
   logic [POP_W-1:0] pop_s;

   always_comb begin
      y_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         y_s[i] = lane_fn(aoi_mode_e'(bus.MODE), bus.A1N[i], bus.A2N[i], bus.B1[i], bus.B2[i]);
      end
   end

   always_comb begin
      pop_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop_s = pop_s + POP_W'(y_s[i]);
      end
   end

   for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
      logic          in_v_s;
      logic [DW-1:0] in_d_s;
      logic          rdy_s;
      logic          out_r_s;
      logic          v_s;
      logic [DW-1:0] d_s;

      if (i == 0) begin : g_head
         assign in_v_s = bus.IN_VALID;
         assign in_d_s = {y_s, pop_s};
      end else begin : g_link
         assign in_v_s = g_stage[i-1].v_s;
         assign in_d_s = g_stage[i-1].d_s;
      end

      if (i == NUM_STAGES - 1) begin : g_tail
         assign out_r_s = bus.OUT_READY;
      end else begin : g_fwd
         assign out_r_s = g_stage[i+1].rdy_s;
      end

      scs8hd_pipe_slice #(
         .DW (DW)
      ) u_slice (
         .clk       (CLK),
         .rst       (RESET),
         .in_valid  (in_v_s),
         .in_ready  (rdy_s),
         .in_data   (in_d_s),
         .out_valid (v_s),
         .out_ready (out_r_s),
         .out_data  (d_s)
      );
   end

   assign bus.IN_READY  = g_stage[0].rdy_s;
   assign bus.OUT_VALID = g_stage[NUM_STAGES-1].v_s;
   assign bus.Y         = g_stage[NUM_STAGES-1].d_s[DW-1:POP_W];
   assign bus.Y_POP     = g_stage[NUM_STAGES-1].d_s[POP_W-1:0];

endmodule

// File: tb/tb_scs8hd_a2bb2oi_pipe.sv
// Bench for scs8hd_a2bb2oi_pipe: directed vectors and sequences on an 8-lane/2-stage
// instance, plus random traffic on 1/1 and 64/4 instances against a word-level FIFO model.
module tb_scs8hd_a2bb2oi_pipe;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   bit   drain = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   scs8hd_a2bb2oi_pipe_if #(.WIDTH(8))  b8 ();
   scs8hd_a2bb2oi_pipe_if #(.WIDTH(1))  b1 ();
   scs8hd_a2bb2oi_pipe_if #(.WIDTH(64)) b64 ();

   scs8hd_a2bb2oi_pipe #(.WIDTH(8),  .STAGES(2)) u_dut8  (.CLK(CLK), .RESET(RESET), .bus(b8));
   scs8hd_a2bb2oi_pipe #(.WIDTH(1),  .STAGES(1)) u_dut1  (.CLK(CLK), .RESET(RESET), .bus(b1));
   scs8hd_a2bb2oi_pipe #(.WIDTH(64), .STAGES(4)) u_dut64 (.CLK(CLK), .RESET(RESET), .bus(b64));

   typedef struct {
      logic [63:0] y;
      int          pop;
   } exp_t;

   typedef struct {
      logic [1:0] mode;
      logic [7:0] a1n;
      logic [7:0] a2n;
      logic [7:0] b1;
      logic [7:0] b2;
      logic [7:0] y;
      int         pop;
   } vec_t;

   exp_t q8[$];
   exp_t q1[$];
   exp_t q64[$];

   // Whole-word reference: the four functions expressed as vector operations.
   function automatic exp_t model(logic [1:0] mode, logic [63:0] a1n, logic [63:0] a2n,
                                  logic [63:0] b1, logic [63:0] b2, int w);
      exp_t        r;
      logic [63:0] mask;
      logic [63:0] a;
      logic [63:0] o;
      logic [63:0] y;
      mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      a = ~a1n & ~a2n;
      o = ~a1n | ~a2n;
      case (mode)
         2'b00:   y = ~(a | (b1 & b2));
         2'b01:   y =   a | (b1 & b2);
         2'b10:   y = ~(o & (b1 | b2));
         default: y =   o & (b1 | b2);
      endcase
      r.y   = y & mask;
      r.pop = $countones(y & mask);
      return r;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive8(logic valid, logic [1:0] mode, logic [7:0] a1n, logic [7:0] a2n,
                         logic [7:0] bb1, logic [7:0] bb2);
      b8.IN_VALID = valid;
      b8.MODE     = mode;
      b8.A1N      = a1n;
      b8.A2N      = a2n;
      b8.B1       = bb1;
      b8.B2       = bb2;
   endtask

   task automatic drive8_rand(logic valid);
      drive8(valid, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   // Scoreboards: outputs must match the oldest accepted transaction for as long as it is shown.
   always @(negedge CLK) begin
      if (RESET) begin
         q8.delete();
      end else begin
         if (b8.OUT_VALID) begin
            checks++;
            if (q8.size() == 0) begin
               errors++;
               $display("FAIL w8_unexpected_output: got Y=%0h with no transaction pending", b8.Y);
            end else begin
               chk("w8_y", 64'(b8.Y), q8[0].y);
               chk("w8_pop", 64'(b8.Y_POP), 64'(q8[0].pop));
               if (b8.OUT_READY) void'(q8.pop_front());
            end
         end
         if (b8.IN_VALID && b8.IN_READY)
            q8.push_back(model(b8.MODE, 64'(b8.A1N), 64'(b8.A2N), 64'(b8.B1), 64'(b8.B2), 8));
      end
   end

   always @(negedge CLK) begin
      if (RESET) begin
         q1.delete();
      end else begin
         if (b1.OUT_VALID) begin
            checks++;
            if (q1.size() == 0) begin
               errors++;
               $display("FAIL w1_unexpected_output: got Y=%0h with no transaction pending", b1.Y);
            end else begin
               chk("w1_y", 64'(b1.Y), q1[0].y);
               chk("w1_pop", 64'(b1.Y_POP), 64'(q1[0].pop));
               if (b1.OUT_READY) void'(q1.pop_front());
            end
         end
         if (b1.IN_VALID && b1.IN_READY)
            q1.push_back(model(b1.MODE, 64'(b1.A1N), 64'(b1.A2N), 64'(b1.B1), 64'(b1.B2), 1));
      end
   end

   always @(negedge CLK) begin
      if (RESET) begin
         q64.delete();
      end else begin
         if (b64.OUT_VALID) begin
            checks++;
            if (q64.size() == 0) begin
               errors++;
               $display("FAIL w64_unexpected_output: got Y=%0h with no transaction pending", b64.Y);
            end else begin
               chk("w64_y", b64.Y, q64[0].y);
               chk("w64_pop", 64'(b64.Y_POP), 64'(q64[0].pop));
               if (b64.OUT_READY) void'(q64.pop_front());
            end
         end
         if (b64.IN_VALID && b64.IN_READY)
            q64.push_back(model(b64.MODE, b64.A1N, b64.A2N, b64.B1, b64.B2, 64));
      end
   end

   // Random traffic for the narrow and wide instances; occasionally forces all-ones/all-zeros.
   initial begin
      while (1) begin
         b1.IN_VALID   = drain ? 1'b0 : 1'($urandom);
         b1.OUT_READY  = drain ? 1'b1 : 1'($urandom);
         b1.MODE       = 2'($urandom_range(0, 3));
         b1.A1N        = 1'($urandom);
         b1.A2N        = 1'($urandom);
         b1.B1         = 1'($urandom);
         b1.B2         = 1'($urandom);
         b64.IN_VALID  = drain ? 1'b0 : 1'($urandom);
         b64.OUT_READY = drain ? 1'b1 : 1'($urandom);
         b64.MODE      = 2'($urandom_range(0, 3));
         b64.A1N       = {$urandom, $urandom};
         b64.A2N       = {$urandom, $urandom};
         b64.B1        = {$urandom, $urandom};
         b64.B2        = {$urandom, $urandom};
         if ($urandom_range(0, 5) == 0) begin
            b64.A1N  = 64'd0;
            b64.A2N  = 64'd0;
            b64.MODE = 2'($urandom_range(0, 1));
         end
         tick();
      end
   end

   vec_t tbl [6];
   int   accepted;
   logic [7:0] held_y;

   initial begin
      tbl[0] = '{2'b00, 8'h0F, 8'h33, 8'h55, 8'hFF, 8'h2A, 3};
      tbl[1] = '{2'b01, 8'h0F, 8'h33, 8'h55, 8'hFF, 8'hD5, 5};
      tbl[2] = '{2'b10, 8'h0F, 8'h33, 8'h55, 8'hFF, 8'h03, 2};
      tbl[3] = '{2'b11, 8'h0F, 8'h33, 8'h55, 8'hFF, 8'hFC, 6};
      tbl[4] = '{2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8};
      tbl[5] = '{2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0};

      // Reset held with a valid input presented.
      RESET = 1'b1;
      drive8(1'b1, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00);
      b8.OUT_READY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("rst_in_ready", 64'(b8.IN_READY), 64'd0);
         chk("rst_out_valid", 64'(b8.OUT_VALID), 64'd0);
         chk("rst_y", 64'(b8.Y), 64'd0);
         chk("rst_y_pop", 64'(b8.Y_POP), 64'd0);
      end
      tick();
      RESET = 1'b0;
      b8.IN_VALID = 1'b0;
      @(negedge CLK);
      chk("post_rst_in_ready", 64'(b8.IN_READY), 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("post_rst_no_output", 64'(b8.OUT_VALID), 64'd0);
      end

      // Truth table and popcount bounds, one isolated transaction each.
      for (int k = 0; k < 6; k++) begin
         tick();
         drive8(1'b1, tbl[k].mode, tbl[k].a1n, tbl[k].a2n, tbl[k].b1, tbl[k].b2);
         @(negedge CLK);
         chk("tt_in_ready", 64'(b8.IN_READY), 64'd1);
         tick();
         b8.IN_VALID = 1'b0;
         @(negedge CLK);
         chk("tt_latency_early", 64'(b8.OUT_VALID), 64'd0);
         tick();
         @(negedge CLK);
         chk("tt_out_valid", 64'(b8.OUT_VALID), 64'd1);
         chk("tt_y", 64'(b8.Y), 64'(tbl[k].y));
         chk("tt_y_pop", 64'(b8.Y_POP), 64'(tbl[k].pop));
         tick();
         @(negedge CLK);
         chk("tt_single_output", 64'(b8.OUT_VALID), 64'd0);
      end

      // Streaming: 16 back-to-back transfers.
      tick();
      for (int i = 0; i < 16; i++) begin
         drive8_rand(1'b1);
         @(negedge CLK);
         chk("stream_in_ready", 64'(b8.IN_READY), 64'd1);
         chk("stream_out_valid", 64'(b8.OUT_VALID), 64'(i >= 2));
         tick();
      end
      b8.IN_VALID = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("stream_tail_valid", 64'(b8.OUT_VALID), 64'(k < 2));
         tick();
      end

      // Backpressure: capacity, hold, then simultaneous pop and push.
      b8.OUT_READY = 1'b0;
      accepted = 0;
      held_y = 8'h00;
      for (int i = 0; i < 4; i++) begin
         drive8_rand(1'b1);
         @(negedge CLK);
         if (b8.IN_VALID && b8.IN_READY) accepted++;
         if (i == 2) held_y = b8.Y;
         if (i == 3) begin
            chk("bp_in_ready_full", 64'(b8.IN_READY), 64'd0);
            chk("bp_out_valid", 64'(b8.OUT_VALID), 64'd1);
            chk("bp_y_hold", 64'(b8.Y), 64'(held_y));
         end
         tick();
      end
      chk("bp_accepted", 64'(accepted), 64'd2);
      b8.OUT_READY = 1'b1;
      @(negedge CLK);
      chk("bp_pop_push_ready", 64'(b8.IN_READY), 64'd1);
      tick();
      b8.OUT_READY = 1'b0;
      @(negedge CLK);
      chk("bp_still_full", 64'(b8.IN_READY), 64'd0);
      chk("bp_still_valid", 64'(b8.OUT_VALID), 64'd1);
      b8.IN_VALID = 1'b0;
      b8.OUT_READY = 1'b1;
      for (int i = 0; i < 4; i++) tick();

      // Reset with two transactions in flight.
      b8.OUT_READY = 1'b0;
      drive8_rand(1'b1);
      tick();
      drive8_rand(1'b1);
      tick();
      b8.IN_VALID = 1'b0;
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      @(negedge CLK);
      chk("mid_rst_out_valid", 64'(b8.OUT_VALID), 64'd0);
      chk("mid_rst_in_ready", 64'(b8.IN_READY), 64'd1);
      b8.OUT_READY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge CLK);
         chk("mid_rst_no_delivery", 64'(b8.OUT_VALID), 64'd0);
      end

      // Random phase on the 8-lane instance, then drain everything.
      for (int i = 0; i < 400; i++) begin
         tick();
         drive8_rand(1'($urandom));
         b8.OUT_READY = 1'($urandom);
      end
      tick();
      b8.IN_VALID = 1'b0;
      b8.OUT_READY = 1'b1;
      drain = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      @(negedge CLK);
      chk("w8_drained", 64'(q8.size()), 64'd0);
      chk("w1_drained", 64'(q1.size()), 64'd0);
      chk("w64_drained", 64'(q64.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
